memtest_sweep_ctrl: RTL and testbench
=====================================

Name: memtest_sweep_ctrl

Overview:
- Control block for the SDRAM memory tester, running in the clock_50_i domain.
- Selects one of N_STEPS SDRAM clock frequencies and sequences the PLL reconfiguration handshake, with timeout recovery.
- Runs a manual or automatic frequency sweep with a per-step dwell time, and records a pass/fail map per step.
- Keeps a BCD elapsed-minutes display and a tenth-second marker counter for the VGA overlay.

Parameters:
- N_STEPS, 11: number of frequency steps; pos 0 is the fastest.
- POS_W, 4: width of pos; must satisfy 2**POS_W >= N_STEPS.
- DEFAULT_POS, 7: pos value after reset.
- CLK_HZ, 50000000: clock_50_i frequency.
- DWELL_SEC, 10: auto-mode test time per step, in seconds.
- RCFG_TIMEOUT, 1000: cycles allowed for the reconfig busy phase.

Ports:
- clock_50_i  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- btn_up  in  1  debounced level; request pos-1
- btn_down  in  1  debounced level; request pos+1
- btn_auto  in  1  debounced level; toggle auto sweep
- pass_seen  in  1  level, already synchronised; tester passcount is nonzero
- fail_seen  in  1  level, already synchronised; tester failcount is nonzero
- rc_busy  in  1  busy flag from pll_reconfig
- rc_write_from_rom  out  1  one-cycle pulse
- rc_reconfig  out  1  one-cycle pulse
- rc_reset  out  1  one-cycle pulse; reconfig engine recovery
- rom_sel  out  POS_W  selects the reconfig ROM; equals pos
- pos  out  POS_W  current step
- recfg  out  1  high while reconfiguring; the top holds the tester in reset
- auto_on  out  1  auto sweep active
- mins  out  16  4-digit BCD elapsed minutes
- tenths  out  3  tenth-second counter, for the marker
- fail_map  out  N_STEPS  bit i = step i failed in the last sweep
- done_map  out  N_STEPS  bit i = step i has been evaluated
- sweep_done  out  1  sticky; auto sweep completed

Behaviour:
- Reset values: pos=DEFAULT_POS, recfg=0, auto_on=0, all rc_* outputs 0, mins=0, tenths=0, fail_map=0, done_map=0, sweep_done=0, FSM in IDLE.
- Edge detect: each button is registered once; a request is a 0->1 transition.
- Requests are ignored while recfg=1.
- Priority within one cycle: RESET > btn_auto > btn_up > btn_down > auto-advance.
- Manual btn_up/btn_down:
  - btn_up with pos>0: pos--, auto_on<=0, start a reconfig.
  - btn_down with pos<N_STEPS-1: pos++, auto_on<=0, start a reconfig.
  - At either bound: no change, no reconfig.
- btn_auto with auto_on=0: pos<=0, auto_on<=1, clear fail_map, done_map and sweep_done, start a reconfig.
- btn_auto with auto_on=1: auto_on<=0, reconfig at the current pos.
- "Start a reconfig" means recfg<=1 and FSM IDLE->LOAD.
- Reconfig FSM:
  - LOAD: rc_write_from_rom=1 for one cycle, then GAP.
  - GAP: one cycle, then ARM.
  - ARM: wait until rc_busy=0; then rc_reconfig=1, load the timeout counter with RCFG_TIMEOUT, go to WAIT.
  - WAIT, normal exit: rc_reconfig=0 (registered) and rc_busy=0 -> IDLE, recfg<=0.
  - WAIT, timeout: counter reaches 1 -> rc_reset=1 -> IDLE, recfg<=0.
  - If both WAIT exits occur in the same cycle, the timeout wins and rc_reset pulses.
- Auto-advance (only when auto_on=1, recfg=0 and FSM in IDLE):
  - A dwell counter counts DWELL_SEC*CLK_HZ cycles from recfg falling.
  - Step fails when fail_seen=1 at any time: set fail_map[pos], set done_map[pos], advance immediately.
  - Step passes at dwell end with fail_seen=0 and pass_seen=1: set done_map[pos], advance.
  - Dwell end with pass_seen=0: counts as a fail.
  - Advance with pos<N_STEPS-1: pos++ and start a reconfig.
  - Advance at the last step: sweep_done<=1, auto_on<=0, pos unchanged, no reconfig.
- Timers:
  - tenths increments every CLK_HZ/10 cycles and wraps 7->0.
  - mins is BCD: each digit wraps 9->0 and carries; 9999->0000. It increments every 60*CLK_HZ cycles.
  - recfg=1 clears mins, tenths, the minute prescaler, the tenth prescaler and the dwell counter.
- Reset mid-reconfig: returns to IDLE with all reset values. pll_reconfig is not reset by this block.

Optional Feature:
- Macro: MEMTEST_SWEEP_LOOP_EN.
- Defined: at the last step, auto sweep sets sweep_done, then returns to pos=0 with a reconfig and stays in auto. fail_map accumulates as a sticky OR across loops; done_map is not cleared.
- Undefined: sweep stops at the last step, as specified above.

Decomposition:
- Package memtest_pkg holds:
  - rcfg_state_t enum: IDLE, LOAD, GAP, ARM, WAIT.
  - Cycle constants derived from CLK_HZ: TENTH_CYC, MIN_CYC.
  - Function bcd4_inc.
- Sub-module memtest_bcd_timer: prescalers, mins, tenths, and a clear input driven by recfg.

Test Plan:
- Release RESET -> pos=7, recfg=0, mins=0000, fail_map=0; no rc_* pulses.
- btn_up pulse with rc_busy=0 -> rc_write_from_rom at T+1, rc_reconfig at T+3, recfg falls T+4 or T+5; pos=6.
- rc_busy held at 1 after rc_reconfig -> rc_reset pulses exactly RCFG_TIMEOUT cycles later; recfg=0.
- With DWELL_SEC overridden to 1 and CLK_HZ to 1000, btn_auto, pass_seen=1, fail_seen asserted only at pos 3 -> pos steps 0..10, fail_map=11'b000_0000_1000, done_map=all ones, sweep_done=1, auto_on=0.
- pos=0 + btn_up, and pos=10 + btn_down -> no reconfig, pos unchanged.
- With CLK_HZ=1000, run 600000 cycles -> mins=0010; pulse btn_down -> mins=0000.

Source files
------------

// File: rtl/memtest_pkg.sv
// rtl/memtest_pkg.sv - shared types, cycle constants and BCD helper for the memtest sweep controller
package memtest_pkg;

   // Reconfiguration handshake states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      GAP  = 3'd2,
      ARM  = 3'd3,
      WAIT = 3'd4
   } rcfg_state_t;

   // Cycle constants for the nominal 50 MHz clock_50_i
   localparam longint CLK_HZ_NOM = 64'd50000000;
   localparam longint TENTH_CYC  = CLK_HZ_NOM / 10;
   localparam longint MIN_CYC    = 64'd60 * CLK_HZ_NOM;

   // Increment a 4-digit packed BCD value; 9999 rolls over to 0000
   function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/memtest_bcd_timer.sv
// rtl/memtest_bcd_timer.sv - tenth-second marker counter and BCD elapsed-minutes display
module memtest_bcd_timer
   import memtest_pkg::*;
#(
   parameter longint TENTH_CYC_P = TENTH_CYC,
   parameter longint MIN_CYC_P   = MIN_CYC
)(
   input  logic        clock_50_i,
   input  logic        RESET,
   input  logic        clear,
   output logic [15:0] mins,
   output logic [2:0]  tenths
);

   localparam int TW = (TENTH_CYC_P > 1) ? $clog2(TENTH_CYC_P) : 1;
   localparam int MW = (MIN_CYC_P > 1) ? $clog2(MIN_CYC_P) : 1;
   localparam logic [TW-1:0] TENTH_LAST = TW'(TENTH_CYC_P - 1);
   localparam logic [MW-1:0] MIN_LAST   = MW'(MIN_CYC_P - 1);

   logic [TW-1:0] tenth_cnt;
   logic [MW-1:0] min_cnt;

   // Tenth-second prescaler; the 3-bit marker counter wraps 7->0 naturally
   always_ff @(posedge clock_50_i) begin
      if (RESET || clear) begin
         tenth_cnt <= '0;
         tenths    <= 3'd0;
      end else if (tenth_cnt == TENTH_LAST) begin
         tenth_cnt <= '0;
         tenths    <= tenths + 3'd1;
      end else begin
         tenth_cnt <= tenth_cnt + TW'(1);
      end
   end

   // Minute prescaler driving the BCD minutes display
   always_ff @(posedge clock_50_i) begin
      if (RESET || clear) begin
         min_cnt <= '0;
         mins    <= 16'h0000;
      end else if (min_cnt == MIN_LAST) begin
         min_cnt <= '0;
         mins    <= bcd4_inc(mins);
      end else begin
         min_cnt <= min_cnt + MW'(1);
      end
   end

endmodule

// File: rtl/memtest_sweep_ctrl.sv
// rtl/memtest_sweep_ctrl.sv - SDRAM test frequency selection, PLL reconfig sequencing and auto sweep; MEMTEST_SWEEP_LOOP_EN makes the auto sweep loop forever
module memtest_sweep_ctrl
   import memtest_pkg::*;
#(
   parameter int     N_STEPS      = 11,
   parameter int     POS_W        = 4,
   parameter int     DEFAULT_POS  = 7,
   parameter longint CLK_HZ       = 50000000,
   parameter longint DWELL_SEC    = 10,
   parameter int     RCFG_TIMEOUT = 1000
)(
   input  logic               clock_50_i,
   input  logic               RESET,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_auto,
   input  logic               pass_seen,
   input  logic               fail_seen,
   input  logic               rc_busy,
   output logic               rc_write_from_rom,
   output logic               rc_reconfig,
   output logic               rc_reset,
   output logic [POS_W-1:0]   rom_sel,
   output logic [POS_W-1:0]   pos,
   output logic               recfg,
   output logic               auto_on,
   output logic [15:0]        mins,
   output logic [2:0]         tenths,
   output logic [N_STEPS-1:0] fail_map,
   output logic [N_STEPS-1:0] done_map,
   output logic               sweep_done
);

   localparam logic [POS_W-1:0] LAST_POS  = POS_W'(N_STEPS - 1);
   localparam longint           DWELL_CYC = DWELL_SEC * CLK_HZ;
   localparam int               DW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [DW-1:0]    DWELL_MAX = DW'(DWELL_CYC - 1);
   localparam int               TOW       = $clog2(RCFG_TIMEOUT + 1);

   rcfg_state_t        state;
   logic [TOW-1:0]     to_cnt;
   logic [DW-1:0]      dwell_cnt;
   logic               dwell_end;
   logic               up_q, down_q, auto_q;
   logic               up_req, down_req, auto_req;
   logic               start;
   logic [POS_W-1:0]   pos_n;
   logic               auto_n;
   logic [N_STEPS-1:0] fail_n, done_n;
   logic               sdone_n;

   assign up_req    = btn_up & ~up_q;
   assign down_req  = btn_down & ~down_q;
   assign auto_req  = btn_auto & ~auto_q;
   assign dwell_end = (dwell_cnt == DWELL_MAX);
   assign rom_sel   = pos;

   // Arbitrate requests and auto-advance; nothing is accepted mid-reconfig
   always_comb begin
      pos_n   = pos;
      auto_n  = auto_on;
      fail_n  = fail_map;
      done_n  = done_map;
      sdone_n = sweep_done;
      start   = 1'b0;
      if (!recfg && state == IDLE) begin
         if (auto_req) begin
            if (!auto_on) begin
               pos_n   = '0;
               auto_n  = 1'b1;
               fail_n  = '0;
               done_n  = '0;
               sdone_n = 1'b0;
            end else begin
               auto_n = 1'b0;
            end
            start = 1'b1;
         end else if (up_req) begin
            if (pos != '0) begin
               pos_n  = pos - POS_W'(1);
               auto_n = 1'b0;
               start  = 1'b1;
            end
         end else if (down_req) begin
            if (pos != LAST_POS) begin
               pos_n  = pos + POS_W'(1);
               auto_n = 1'b0;
               start  = 1'b1;
            end
         end else if (auto_on && (fail_seen || dwell_end)) begin
            done_n[pos] = 1'b1;
            if (fail_seen || !pass_seen) begin
               fail_n[pos] = 1'b1;
            end
            if (pos != LAST_POS) begin
               pos_n = pos + POS_W'(1);
               start = 1'b1;
            end else begin
               sdone_n = 1'b1;
`ifdef MEMTEST_SWEEP_LOOP_EN
               pos_n = '0;
               start = 1'b1;
`else
               auto_n = 1'b0;
`endif
            end
         end
      end
   end

   // Button edge registers and sweep bookkeeping
   always_ff @(posedge clock_50_i) begin
      if (RESET) begin
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         auto_q     <= 1'b0;
         pos        <= POS_W'(DEFAULT_POS);
         auto_on    <= 1'b0;
         fail_map   <= '0;
         done_map   <= '0;
         sweep_done <= 1'b0;
      end else begin
         up_q       <= btn_up;
         down_q     <= btn_down;
         auto_q     <= btn_auto;
         pos        <= pos_n;
         auto_on    <= auto_n;
         fail_map   <= fail_n;
         done_map   <= done_n;
         sweep_done <= sdone_n;
      end
   end

   // Dwell timer starts when reconfig finishes and saturates at the dwell end
   always_ff @(posedge clock_50_i) begin
      if (RESET || recfg || !auto_on) begin
         dwell_cnt <= '0;
      end else if (state == IDLE && !dwell_end) begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

   // PLL reconfig handshake; a timeout beats a normal completion in the same cycle
   always_ff @(posedge clock_50_i) begin
      if (RESET) begin
         state             <= IDLE;
         recfg             <= 1'b0;
         to_cnt            <= '0;
         rc_write_from_rom <= 1'b0;
         rc_reconfig       <= 1'b0;
         rc_reset          <= 1'b0;
      end else begin
         rc_write_from_rom <= 1'b0;
         rc_reconfig       <= 1'b0;
         rc_reset          <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  recfg <= 1'b1;
               end
            end
            LOAD: begin
               rc_write_from_rom <= 1'b1;
               state             <= GAP;
            end
            GAP: begin
               state <= ARM;
            end
            ARM: begin
               if (!rc_busy) begin
                  rc_reconfig <= 1'b1;
                  to_cnt      <= TOW'(RCFG_TIMEOUT);
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (to_cnt == TOW'(1)) begin
                  rc_reset <= 1'b1;
                  state    <= IDLE;
                  recfg    <= 1'b0;
               end else begin
                  to_cnt <= to_cnt - TOW'(1);
                  if (!rc_reconfig && !rc_busy) begin
                     state <= IDLE;
                     recfg <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               recfg <= 1'b0;
            end
         endcase
      end
   end

   memtest_bcd_timer #(
      .TENTH_CYC_P (CLK_HZ / 10),
      .MIN_CYC_P   (64'd60 * CLK_HZ)
   ) u_timer (
      .clock_50_i (clock_50_i),
      .RESET      (RESET),
      .clear      (recfg),
      .mins       (mins),
      .tenths     (tenths)
   );

endmodule

// File: tb/tb_memtest_sweep_ctrl.sv
// tb/tb_memtest_sweep_ctrl.sv - directed self-checking bench with a rom_sel scoreboard
module tb_memtest_sweep_ctrl;

   localparam int     N_STEPS = 11;
   localparam int     POS_W   = 4;
   localparam longint CLK_HZ  = 20;
   localparam int     MIN_C   = 60 * 20;

   logic               clock_50_i = 1'b0;
   logic               RESET;
   logic               btn_up, btn_down, btn_auto;
   logic               pass_seen, fail_seen, rc_busy;
   logic               rc_write_from_rom, rc_reconfig, rc_reset;
   logic [POS_W-1:0]   rom_sel, pos;
   logic               recfg, auto_on, sweep_done;
   logic [15:0]        mins;
   logic [2:0]         tenths;
   logic [N_STEPS-1:0] fail_map, done_map;

   int vecs = 0;
   int errs = 0;
   int exp_q[$];
   bit fail_inject = 1'b0;

   memtest_sweep_ctrl #(
      .N_STEPS(N_STEPS), .POS_W(POS_W), .DEFAULT_POS(7),
      .CLK_HZ(CLK_HZ), .DWELL_SEC(1), .RCFG_TIMEOUT(1000)
   ) dut (
      .clock_50_i(clock_50_i), .RESET(RESET),
      .btn_up(btn_up), .btn_down(btn_down), .btn_auto(btn_auto),
      .pass_seen(pass_seen), .fail_seen(fail_seen), .rc_busy(rc_busy),
      .rc_write_from_rom(rc_write_from_rom), .rc_reconfig(rc_reconfig), .rc_reset(rc_reset),
      .rom_sel(rom_sel), .pos(pos), .recfg(recfg), .auto_on(auto_on),
      .mins(mins), .tenths(tenths), .fail_map(fail_map), .done_map(done_map),
      .sweep_done(sweep_done)
   );

   always #10 clock_50_i = ~clock_50_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // fail_seen stands in for the tester: failures only at step 3 once out of reconfig
   always @(negedge clock_50_i) fail_seen = fail_inject && (pos == 4'd3) && !recfg;

   // Scoreboard: every ROM load must select the next expected step
   always @(negedge clock_50_i) begin
      if (rc_write_from_rom) begin
         if (exp_q.size() == 0) check("wfr_unexpected", 32'(rom_sel), 32'hFFFF);
         else check("wfr_rom_sel", 32'(rom_sel), 32'(exp_q.pop_front()));
      end
   end

   task automatic pulse(input int which, input int exp_rom, input bit expect_rcfg);
      @(negedge clock_50_i);
      if (expect_rcfg) exp_q.push_back(exp_rom);
      case (which)
         0:       btn_up   = 1'b1;
         1:       btn_down = 1'b1;
         default: btn_auto = 1'b1;
      endcase
      @(negedge clock_50_i);
      btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0;
   endtask

   task automatic wait_rcfg_done(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock_50_i);
         if (!recfg) break;
      end
      check(tag, 32'(recfg), 32'd0);
   endtask

   initial begin
      int n;
      bit seen;
      bit any;
      RESET = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0;
      pass_seen = 1'b1; rc_busy = 1'b0;
      repeat (3) @(posedge clock_50_i);
      @(negedge clock_50_i);
      RESET = 1'b0;

      check("rst_pos", 32'(pos), 32'd7);
      check("rst_recfg", 32'(recfg), 32'd0);
      check("rst_auto", 32'(auto_on), 32'd0);
      check("rst_mins", 32'(mins), 32'h0);
      check("rst_tenths", 32'(tenths), 32'd0);
      check("rst_fail_map", 32'(fail_map), 32'd0);
      check("rst_done_map", 32'(done_map), 32'd0);
      check("rst_sweep_done", 32'(sweep_done), 32'd0);
      check("rst_rc", 32'({rc_write_from_rom, rc_reconfig, rc_reset}), 32'd0);

      // Handshake latency on a manual step
      pulse(0, 6, 1'b1);
      check("t0_recfg", 32'(recfg), 32'd1);
      check("t0_pos", 32'(pos), 32'd6);
      check("t0_wfr", 32'(rc_write_from_rom), 32'd0);
      @(negedge clock_50_i); check("t1_wfr", 32'(rc_write_from_rom), 32'd1);
      @(negedge clock_50_i); check("t2_reconfig", 32'(rc_reconfig), 32'd0);
      @(negedge clock_50_i); check("t3_reconfig", 32'(rc_reconfig), 32'd1);
      @(negedge clock_50_i);
      @(negedge clock_50_i); check("t5_recfg", 32'(recfg), 32'd0);

      // Timeout recovery with the reconfig engine stuck busy
      pulse(1, 7, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_50_i);
         if (rc_reconfig) begin seen = 1'b1; break; end
      end
      check("to_reconfig_seen", 32'(seen), 32'd1);
      rc_busy = 1'b1;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clock_50_i);
         n++;
         if (rc_reset) begin seen = 1'b1; break; end
      end
      check("to_reset_seen", 32'(seen), 32'd1);
      check("to_cycles", 32'(n), 32'd1000);
      check("to_recfg", 32'(recfg), 32'd0);
      check("to_pos", 32'(pos), 32'd7);
      rc_busy = 1'b0;

      // Full auto sweep with a failure at step 3
      fail_inject = 1'b1;
      pulse(2, 0, 1'b1);
      for (int k = 1; k < N_STEPS; k++) exp_q.push_back(k);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock_50_i);
         if (sweep_done) break;
      end
      fail_inject = 1'b0;
      check("sw_done", 32'(sweep_done), 32'd1);
      check("sw_fail_map", 32'(fail_map), 32'h008);
      check("sw_done_map", 32'(done_map), 32'h7FF);
      check("sw_auto_off", 32'(auto_on), 32'd0);
      check("sw_pos", 32'(pos), 32'd10);

      // btn_down at the slow bound does nothing
      pulse(1, 0, 1'b0);
      any = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_50_i);
         any |= recfg;
      end
      check("bnd_dn_recfg", 32'(any), 32'd0);
      check("bnd_dn_pos", 32'(pos), 32'd10);

      // Auto on clears the maps, auto off reconfigures at the current step
      pulse(2, 0, 1'b1);
      wait_rcfg_done("ao_rcfg_done");
      check("ao_auto", 32'(auto_on), 32'd1);
      check("ao_pos", 32'(pos), 32'd0);
      check("ao_maps", 32'({fail_map, done_map, sweep_done}), 32'd0);
      pulse(2, 0, 1'b1);
      wait_rcfg_done("af_rcfg_done");
      check("af_auto", 32'(auto_on), 32'd0);
      check("af_pos", 32'(pos), 32'd0);

      // btn_up at the fast bound does nothing
      pulse(0, 0, 1'b0);
      any = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_50_i);
         any |= recfg;
      end
      check("bnd_up_recfg", 32'(any), 32'd0);
      check("bnd_up_pos", 32'(pos), 32'd0);

      // Elapsed-time counters measured from the end of a reconfig
      pulse(1, 1, 1'b1);
      wait_rcfg_done("tm_rcfg_done");
      for (int i = 1; i <= 10 * MIN_C; i++) begin
         @(negedge clock_50_i);
         if (i == 7) check("tm_tenths_3", 32'(tenths), 32'd3);
         if (i == 10 * MIN_C - 1) check("tm_mins_0009", 32'(mins), 32'h0009);
         if (i == 10 * MIN_C) begin
            check("tm_mins_0010", 32'(mins), 32'h0010);
            check("tm_tenths_wrap", 32'(tenths), 32'd0);
         end
      end

      // A reconfig clears the display
      pulse(1, 2, 1'b1);
      @(negedge clock_50_i);
      check("clr_mins", 32'(mins), 32'h0);
      check("clr_tenths", 32'(tenths), 32'd0);
      wait_rcfg_done("clr_rcfg_done");
      repeat (4) @(negedge clock_50_i);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
